rgb2ycbcr_pipe: RTL



---
 rtl/rgb2ycbcr_if.sv | 27 ++
 rtl/rgb2ycbcr_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_if.sv
// Pixel stream bundle for the RGB to YCbCr converter: input beat side, output beat side,
// each with its own valid/ready handshake.
interface rgb2ycbcr_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 1
);
  logic [1:0]               mode;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*3*PIX_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*3*PIX_W-1:0] out_data;
  logic [LANES-1:0]         out_sat;

  // Converter view.
  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  // Pixel source / sink view.
  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// Three-stage RGB to YCbCr converter (BT.601 / BT.709 full range, or bypass) for LANES
// pixels per beat, with a single global stall driven by the output handshake.
module rgb2ycbcr_pipe #(
  parameter int PIX_W = 8,
  parameter int LANES = 1,
  parameter int FRAC  = 14
) (
  input  logic           clk,
  input  logic           rst,
  rgb2ycbcr_if.slave     bus
);

  localparam int COEF_W = 16;
  localparam int PROD_W = PIX_W + 1 + COEF_W;
  localparam int SUM_W  = PIX_W + FRAC + 4;
  localparam int BEAT_W = LANES * 3 * PIX_W;

  localparam logic signed [SUM_W-1:0] ONE        = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] ROUND_K    = ONE <<< (FRAC - 1);
  localparam logic signed [SUM_W-1:0] CHROMA_OFF = ONE <<< (PIX_W - 1 + FRAC);
  localparam logic signed [SUM_W-1:0] MAX_V      = (ONE <<< PIX_W) - ONE;

  // Row-major {Y, Cb, Cr} x {R, G, B}; bypass is an identity matrix so it shares the datapath.
  localparam logic signed [COEF_W-1:0] K601 [9] = '{
    16'sd4899,  16'sd9617,  16'sd1868,
    -16'sd2764, -16'sd5428, 16'sd8192,
    16'sd8192,  -16'sd6860, -16'sd1332
  };
  localparam logic signed [COEF_W-1:0] K709 [9] = '{
    16'sd3483,  16'sd11718, 16'sd1183,
    -16'sd1878, -16'sd6314, 16'sd8192,
    16'sd8192,  -16'sd7442, -16'sd750
  };
  localparam logic signed [COEF_W-1:0] KBYP [9] = '{
    16'sd16384, 16'sd0,     16'sd0,
    16'sd0,     16'sd16384, 16'sd0,
    16'sd0,     16'sd0,     16'sd16384
  };

  function automatic logic signed [COEF_W-1:0] coef(input logic [1:0] m, input int idx);
    case (m)
      2'b01:   return K709[idx];
      2'b10:   return KBYP[idx];
      default: return K601[idx];
    endcase
  endfunction

  // Returns {clamped, value} after the FRAC-bit arithmetic shift.
  function automatic logic [PIX_W:0] round_sat(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> FRAC;
    if (q[SUM_W-1])
      return {1'b1, {PIX_W{1'b0}}};
    else if (q > MAX_V)
      return {1'b1, {PIX_W{1'b1}}};
    else
      return {1'b0, q[PIX_W-1:0]};
  endfunction

  logic                     advance;
  logic                     vld_p1, vld_p2, vld_p3;
  logic [1:0]               mode_p1;
  logic signed [PROD_W-1:0] prod_c  [LANES][9];
  logic signed [PROD_W-1:0] prod_p1 [LANES][9];
  logic signed [SUM_W-1:0]  sum_c   [LANES][3];
  logic signed [SUM_W-1:0]  sum_p2  [LANES][3];
  logic [BEAT_W-1:0]        res_c;
  logic [LANES-1:0]         sat_c;
  logic [BEAT_W-1:0]        data_p3;
  logic [LANES-1:0]         sat_p3;

  assign advance      = !vld_p3 || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = vld_p3;
  assign bus.out_data  = data_p3;
  assign bus.out_sat   = sat_p3;

  // Stage 1: coefficient x component products
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < 9; j++) begin
        logic signed [PROD_W-1:0] comp_ext;
        logic signed [PROD_W-1:0] coef_ext;
        comp_ext = $signed({{(PROD_W-PIX_W){1'b0}},
                            bus.in_data[l*3*PIX_W + (j%3)*PIX_W +: PIX_W]});
        coef_ext = PROD_W'(coef(bus.mode, j));
        prod_c[l][j] = comp_ext * coef_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      mode_p1 <= '0;
      for (int l = 0; l < LANES; l++)
        for (int j = 0; j < 9; j++)
          prod_p1[l][j] <= '0;
    end else if (advance) begin
      vld_p1  <= bus.in_valid;
      mode_p1 <= bus.mode;
      for (int l = 0; l < LANES; l++)
        for (int j = 0; j < 9; j++)
          prod_p1[l][j] <= prod_c[l][j];
    end
  end

  // Stage 2: signed sums with rounding constant and chroma offset
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 3; k++) begin
        sum_c[l][k] = SUM_W'(prod_p1[l][3*k]) + SUM_W'(prod_p1[l][3*k+1])
                    + SUM_W'(prod_p1[l][3*k+2]) + ROUND_K;
        if (k != 0 && mode_p1 != 2'b10)
          sum_c[l][k] = sum_c[l][k] + CHROMA_OFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < 3; k++)
          sum_p2[l][k] <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < 3; k++)
          sum_p2[l][k] <= sum_c[l][k];
    end
  end

  // Stage 3: shift, clamp and register the output beat
  always_comb begin
    res_c = '0;
    sat_c = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 3; k++) begin
        logic [PIX_W:0] rs;
        rs = round_sat(sum_p2[l][k]);
        res_c[l*3*PIX_W + k*PIX_W +: PIX_W] = rs[PIX_W-1:0];
        sat_c[l] = sat_c[l] | rs[PIX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      data_p3 <= '0;
      sat_p3  <= '0;
    end else if (advance) begin
      vld_p3  <= vld_p2;
      data_p3 <= res_c;
      sat_p3  <= sat_c;
    end
  end

endmodule
